// File: rtl/up_fetch_unit_pkg.sv
// Shared definitions for the nibble-core fetch/sequencing front end: state encoding,
// phase values and the default field widths that decode and ALU blocks agree on.
package up_fetch_unit_pkg;

    localparam int unsigned DEF_ADDR_W  = 12;
    localparam int unsigned DEF_INSTR_W = 4;
    localparam int unsigned DEF_OPRND_W = 4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam logic PHASE_FETCH = 1'b0;
    localparam logic PHASE_EXEC  = 1'b1;

endpackage

// File: rtl/up_fetch_unit_if.sv
// Bus bundle between the fetch unit, program ROM and the decode/ALU datapath.
// The master side is the fetch unit; the slave side is ROM plus datapath.
interface up_fetch_unit_if
    import up_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned OPRND_W = DEF_OPRND_W
);
    logic [INSTR_W+OPRND_W-1:0] prog_byte;
    logic                       prog_valid;
    logic                       pc_req;
    logic [ADDR_W-1:0]          pc;
    logic [INSTR_W-1:0]         instr;
    logic [OPRND_W-1:0]         oprnd;
    logic                       phase;
    logic                       exec_done;
    logic                       stall;
    logic                       jump_en;
    logic [ADDR_W-1:0]          jump_addr;
    logic                       skip_en;
    logic                       halt_req;
    logic                       halted;

    modport master (
        input  prog_byte, prog_valid, exec_done, stall, jump_en, jump_addr, skip_en, halt_req,
        output pc_req, pc, instr, oprnd, phase, halted
    );

    modport slave (
        output prog_byte, prog_valid, exec_done, stall, jump_en, jump_addr, skip_en, halt_req,
        input  pc_req, pc, instr, oprnd, phase, halted
    );

endinterface

// File: rtl/up_pc_next.sv
// Combinational next-PC select: jump target beats skip (+2) beats increment (+1).
// Arithmetic wraps modulo 2^ADDR_W.
module up_pc_next #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_jump_en,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_skip_en,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] w_step;

    always_comb begin
        w_step    = i_skip_en ? ADDR_W'(2) : ADDR_W'(1);
        o_pc_next = i_jump_en ? i_jump_addr : i_pc + w_step;
    end

endmodule

// File: rtl/up_fetch_unit.sv
// Fetch/execute sequencer for the nibble core: ROM wait-state handshake, execute-complete
// handshake, stall, jump/skip and halt. All outputs come straight from registers.
module up_fetch_unit
    import up_fetch_unit_pkg::*;
#(
    parameter int unsigned     ADDR_W    = DEF_ADDR_W,
    parameter int unsigned     INSTR_W   = DEF_INSTR_W,
    parameter int unsigned     OPRND_W   = DEF_OPRND_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic            clock,
    input logic            reset,
    up_fetch_unit_if.master bus
);

    fetch_state_e       r_state, w_state_d;
    logic [ADDR_W-1:0]  r_pc, w_pc_d, w_pc_next;
    logic [INSTR_W-1:0] r_instr, w_instr_d;
    logic [OPRND_W-1:0] r_oprnd, w_oprnd_d;
    logic               r_phase;
    logic               r_pc_req;
    logic               r_halted;

    up_pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .i_pc       (r_pc),
        .i_jump_en  (bus.jump_en),
        .i_jump_addr(bus.jump_addr),
        .i_skip_en  (bus.skip_en),
        .o_pc_next  (w_pc_next)
    );

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_instr_d = r_instr;
        w_oprnd_d = r_oprnd;
        if (!bus.stall) begin
            unique case (r_state)
                ST_FETCH: begin
                    if (bus.prog_valid) begin
                        w_instr_d = bus.prog_byte[INSTR_W+OPRND_W-1 -: INSTR_W];
                        w_oprnd_d = bus.prog_byte[OPRND_W-1:0];
                        w_state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bus.exec_done) begin
                        w_pc_d    = w_pc_next;
                        w_state_d = bus.halt_req ? ST_HALT : ST_FETCH;
                    end
                end
                ST_HALT: w_state_d = ST_HALT;
                default: w_state_d = ST_FETCH;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they stay registered (Moore).
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_VEC;
            r_instr  <= '0;
            r_oprnd  <= '0;
            r_phase  <= PHASE_FETCH;
            r_pc_req <= 1'b1;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_pc     <= w_pc_d;
            r_instr  <= w_instr_d;
            r_oprnd  <= w_oprnd_d;
            r_phase  <= (w_state_d == ST_EXEC) ? PHASE_EXEC : PHASE_FETCH;
            r_pc_req <= (w_state_d == ST_FETCH);
            r_halted <= (w_state_d == ST_HALT);
        end
    end

    assign bus.pc     = r_pc;
    assign bus.instr  = r_instr;
    assign bus.oprnd  = r_oprnd;
    assign bus.phase  = r_phase;
    assign bus.pc_req = r_pc_req;
    assign bus.halted = r_halted;

endmodule

// File: tb/tb_up_fetch_unit.sv
// Self-checking bench for up_fetch_unit: directed scenarios followed by random stimulus,
// compared every cycle against a behavioural model of the fetch/execute sequencing rules.
module tb_up_fetch_unit;

    localparam int unsigned AW    = 12;
    localparam int unsigned IW    = 4;
    localparam int unsigned OW    = 4;
    localparam int unsigned RV    = 12'h000;
    localparam int unsigned PCMOD = 1 << AW;

    localparam int MODE_FETCH = 0;
    localparam int MODE_EXEC  = 1;
    localparam int MODE_HALT  = 2;

    logic clock;
    logic reset;

    up_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .OPRND_W(OW)) bus ();

    up_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .OPRND_W  (OW),
        .RESET_VEC(AW'(RV))
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    logic [7:0] rom [PCMOD];
    assign bus.prog_byte = rom[bus.pc];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pc    = 0;
    int m_instr = 0;
    int m_oprnd = 0;
    int m_mode  = MODE_FETCH;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit stl, input bit pv, input bit ed,
                              input bit je, input int ja, input bit se, input bit hr,
                              input int rom_byte);
        if (!rst) begin
            m_pc    = RV;
            m_instr = 0;
            m_oprnd = 0;
            m_mode  = MODE_FETCH;
        end else if (!stl) begin
            if (m_mode == MODE_FETCH && pv) begin
                m_instr = rom_byte / 16;
                m_oprnd = rom_byte % 16;
                m_mode  = MODE_EXEC;
            end else if (m_mode == MODE_EXEC && ed) begin
                if (je)      m_pc = ja;
                else if (se) m_pc = (m_pc + 2) % PCMOD;
                else         m_pc = (m_pc + 1) % PCMOD;
                m_mode = hr ? MODE_HALT : MODE_FETCH;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output.
    task automatic cycle(input bit rst, input bit stl, input bit pv, input bit ed,
                         input bit je, input int ja, input bit se, input bit hr);
        int rom_byte;
        reset         = rst;
        bus.stall     = stl;
        bus.prog_valid = pv;
        bus.exec_done = ed;
        bus.jump_en   = je;
        bus.jump_addr = AW'(ja);
        bus.skip_en   = se;
        bus.halt_req  = hr;
        rom_byte = int'(rom[m_pc]);
        @(posedge clock);
        model_step(rst, stl, pv, ed, je, ja, se, hr, rom_byte);
        #1;
        check("pc",     32'(bus.pc),     32'(m_pc));
        check("instr",  32'(bus.instr),  32'(m_instr));
        check("oprnd",  32'(bus.oprnd),  32'(m_oprnd));
        check("phase",  32'(bus.phase),  32'(m_mode == MODE_EXEC));
        check("pc_req", 32'(bus.pc_req), 32'(m_mode == MODE_FETCH));
        check("halted", 32'(bus.halted), 32'(m_mode == MODE_HALT));
    endtask

    initial begin
        for (int i = 0; i < int'(PCMOD); i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA5;

        // Reset, then straight-line fetch/execute
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_instr_lit", 32'(bus.instr), 32'h0);
        cycle(1, 0, 1, 1, 0, 0, 0, 0);
        check("a5_instr", 32'(bus.instr), 32'hA);
        check("a5_oprnd", 32'(bus.oprnd), 32'h5);
        cycle(1, 0, 1, 1, 0, 0, 0, 0);
        check("pc_after2", 32'(bus.pc), 32'h1);
        cycle(1, 0, 1, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0, 0, 0, 0);
        check("pc_after4", 32'(bus.pc), 32'h2);

        // Wait states
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 0, 0);

        // Jump near the top, skip across the wrap, jump beats skip
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 'hFFE, 0, 0);
        check("jump_ffe", 32'(bus.pc), 32'hFFE);
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 1, 0);
        check("skip_wrap", 32'(bus.pc), 32'h000);
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 'h123, 1, 0);
        check("jump_prio", 32'(bus.pc), 32'h123);

        // Increment wrap at all-ones
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 'hFFF, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 0, 0);
        check("inc_wrap", 32'(bus.pc), 32'h000);

        // Stall in EXEC with exec_done
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1, 'h777, 0, 0);
        cycle(1, 1, 1, 1, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 0, 0, 0, 0);
        check("stall_inc", 32'(bus.pc), 32'h001);

        // Halt at pc=5
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 5, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 0, 1);
        check("halt_pc", 32'(bus.pc), 32'h6);
        check("halt_flag", 32'(bus.halted), 32'h1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1, i[0], 'h3, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("unhalt", 32'(bus.halted), 32'h0);

        // Reset during a FETCH wait state and during EXEC, with stall held
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 'h40, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("rst_wait_pc", 32'(bus.pc), 32'(RV));
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0, 0, 0);
        check("rst_exec_ph", 32'(bus.phase), 32'h0);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, PCMOD - 1)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 23) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/up_fetch_unit.md
Name: up_fetch_unit

Overview:
Parametrised fetch/sequencing front end for the nibble microprocessor family. It generalises the fixed two-phase, 12-bit-PC, 4+4-bit program-byte core into a configurable address/instruction/operand width.
- Adds a wait-state handshake to program memory, an execute-complete handshake, stall, jump, skip and halt.
- Sits between program ROM and the decode/ALU datapath.
- Drives PC, instr, oprnd and phase to the rest of the core.

Parameters:
ADDR_W, 12, program counter / ROM address width
INSTR_W, 4, opcode field width (upper bits of program byte)
OPRND_W, 4, operand field width (lower bits of program byte)
RESET_VEC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
prog_byte  input  INSTR_W+OPRND_W  program ROM data at address pc
prog_valid  input  1  ROM data valid this cycle (wait-state handshake)
pc_req  output  1  fetch request, ROM read of address pc
pc  output  ADDR_W  program counter
instr  output  INSTR_W  latched opcode = prog_byte[MSBs]
oprnd  output  OPRND_W  latched operand = prog_byte[LSBs]
phase  output  1  0 = fetch, 1 = execute
exec_done  input  1  datapath finished executing current instruction
stall  input  1  freeze all state this cycle
jump_en  input  1  sampled with exec_done; load jump_addr
jump_addr  input  ADDR_W  branch target
skip_en  input  1  sampled with exec_done; PC advances by 2
halt_req  input  1  sampled with exec_done; enter HALT
halted  output  1  core is halted

Behaviour:
- Reset applies when reset==0 at a rising edge and has priority over stall and every other input, including mid-fetch and mid-execute. Reset values:
  - pc=RESET_VEC, instr=0, oprnd=0, phase=0, pc_req=1, halted=0, state=FETCH.
- States are FETCH, EXEC and HALT.
- FETCH: phase=0, pc_req=1.
  - If prog_valid=1 and stall=0: latch instr/oprnd from prog_byte, go to EXEC next cycle.
  - If prog_valid=0: remain in FETCH; pc, instr and oprnd hold (unbounded wait states).
- EXEC: phase=1, pc_req=0. Remain until exec_done=1 with stall=0, then update pc:
  - jump_en=1: pc=jump_addr.
  - else skip_en=1: pc=pc+2 mod 2^ADDR_W.
  - else: pc=pc+1 mod 2^ADDR_W.
  - Priority is jump > skip > increment; pc wraps silently (all-ones+1 -> 0, all-ones+2 -> 1).
  - Next state is HALT if halt_req=1, else FETCH.
  - halt_req combined with jump/skip: pc is still updated, then the unit halts.
- HALT: phase=0, pc_req=0, halted=1. pc, instr and oprnd hold. Only reset exits HALT.
- stall=1 (reset inactive) freezes state, pc, instr, oprnd and phase. Outputs hold their values. exec_done, prog_valid, jump_en, skip_en and halt_req are ignored in a stalled cycle.
- Latency:
  - Minimum instruction period is 2 cycles (fetch with prog_valid, execute with exec_done).
  - Each wait state or exec cycle without exec_done adds 1 cycle.
- instr and oprnd change only on a FETCH accept. They stay stable throughout EXEC.
- exec_done, jump_en, skip_en and halt_req are ignored outside EXEC.
- All outputs are registered (Moore). There is no combinational path from input to output.

Decomposition:
- Shared package holds:
  - the state encoding constants (ST_FETCH=2'd0, ST_EXEC=2'd1, ST_HALT=2'd2);
  - PHASE_FETCH/PHASE_EXEC;
  - the default widths (ADDR_W, INSTR_W, OPRND_W) so the decode and ALU blocks agree on the field split.
- One natural sub-module: up_pc_next. It is a combinational next-PC select (jump/skip/increment with wrap), parametrised by ADDR_W.
- The FSM and the instr/oprnd registers stay in the top module.

Test Plan:
- Reset and straight-line fetch: reset=0 for one edge, then 1; prog_valid=1, exec_done=1 every EXEC; ROM[0]=8'hA5 -> pc=0, instr=4'hA, oprnd=4'h5, phase toggles 0,1,0,1, pc=1 after the second edge, pc=2 after the fourth.
- Wait states: prog_valid=0 for 3 cycles in FETCH -> pc_req=1, phase=0 held, instr unchanged for 3 cycles; latch occurs on the cycle prog_valid=1.
- Jump, skip and wrap (ADDR_W=12):
  - jump_en=1 with jump_addr=12'hFFE and exec_done -> pc=12'hFFE.
  - next skip_en=1 -> pc=12'h000.
  - jump_en and skip_en together with jump_addr=12'h123 -> pc=12'h123.
- Stall: stall=1 in EXEC with exec_done=1 for 2 cycles -> pc, phase and instr unchanged. Drop stall with exec_done=1 -> pc increments once.
- Halt: halt_req=1 with exec_done at pc=5 -> pc=6, halted=1, pc_req=0. Further exec_done/prog_valid cause no change until reset=0, after which pc=RESET_VEC and halted=0.
- Reset mid-operation: assert reset=0 during a FETCH wait state and again during EXEC -> next edge gives pc=RESET_VEC, instr=0, oprnd=0, phase=0, even with stall=1 asserted.
